// File: rtl/vga_pkg.sv
// Shared VGA defaults (640x480@60), coordinate/colour types, colour-bar table
// and the porch/sync total helper used by every display block.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 10;
  localparam int DEF_PIX_W    = 12;

  typedef logic [DEF_CW-1:0]    coord_t;
  typedef logic [DEF_PIX_W-1:0] rgb_t;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb_t BAR_COLORS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                      12'hF0F, 12'hF00, 12'h00F, 12'h000};

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with active-area and raw (active-high)
// sync flags; polarity and pipelining are left to the instantiating block.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] h,
  output logic [CW-1:0] v,
  output logic          active,
  output logic          hs_on,
  output logic          vs_on
);
  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  logic [CW-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h      = h_q;
  assign v      = v_q;
  assign active = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
  assign hs_on  = (int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_on  = (int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC);
endmodule

// File: rtl/vga_window_display.sv
// VGA raster with NWIN priority-composited windows over a background colour.
// Optional colour-bar generator enabled by defining TEST_PATTERN_EN.
module vga_window_display
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0,
  parameter int NWIN     = 2,
  parameter int CW       = DEF_CW,
  parameter int PIX_W    = DEF_PIX_W,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef TEST_PATTERN_EN
  input  logic                  test_mode,
`endif
  input  logic [NWIN-1:0]       win_en,
  input  logic [NWIN*CW-1:0]    win_xl,
  input  logic [NWIN*CW-1:0]    win_xr,
  input  logic [NWIN*CW-1:0]    win_yu,
  input  logic [NWIN*CW-1:0]    win_yd,
  input  logic [NWIN*PIX_W-1:0] pixel,
  output logic [NWIN-1:0]       pix_req,
  output logic [CW-1:0]         pix_x,
  output logic [CW-1:0]         pix_y,
  output logic [PIX_W-1:0]      rgb,
  output logic                  hs,
  output logic                  vs,
  output logic                  de,
  output logic                  frame_start
);
  localparam int   IW       = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [CW-1:0] h, v;
  logic          active, hs_on, vs_on, frame_top;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CW(CW)
  ) u_timing (
    .clk(clk), .rst(rst), .h(h), .v(v),
    .active(active), .hs_on(hs_on), .vs_on(vs_on)
  );

  assign frame_top = (h == '0) && (v == '0);

  // Shadow bounds; the _d side bypasses so pixel (0,0) already sees new bounds.
  logic [NWIN-1:0]    sh_en_q, sh_en_d;
  logic [NWIN*CW-1:0] sh_xl_q, sh_xl_d, sh_xr_q, sh_xr_d;
  logic [NWIN*CW-1:0] sh_yu_q, sh_yu_d, sh_yd_q, sh_yd_d;

  always_comb begin
    sh_en_d = sh_en_q;
    sh_xl_d = sh_xl_q;
    sh_xr_d = sh_xr_q;
    sh_yu_d = sh_yu_q;
    sh_yd_d = sh_yd_q;
    if (frame_top) begin
      sh_en_d = win_en;
      sh_xl_d = win_xl;
      sh_xr_d = win_xr;
      sh_yu_d = win_yu;
      sh_yd_d = win_yd;
    end
  end

  logic [NWIN-1:0] hit;
  for (genvar i = 0; i < NWIN; i++) begin : g_win
    logic [CW-1:0] xl, xr, yu, yd;
    assign xl = sh_xl_d[i*CW +: CW];
    assign xr = sh_xr_d[i*CW +: CW];
    assign yu = sh_yu_d[i*CW +: CW];
    assign yd = sh_yd_d[i*CW +: CW];
    assign hit[i] = sh_en_d[i] & active & (h >= xl) & (h <= xr) & (v >= yu) & (v <= yd);
  end

  // Stage 1: winner select and source read strobe
  logic [NWIN-1:0] hit_g, req_d, req_q;
  logic [IW-1:0]   win_d, win1_q;
  logic            any_d, any1_q, act1_q, hs1_q, vs1_q, fs1_q;
  logic [CW-1:0]   x_q, y_q;

  always_comb begin
    hit_g = hit;
`ifdef TEST_PATTERN_EN
    if (test_mode) hit_g = '0;
`endif
    req_d = hit_g & (~hit_g + 1'b1);
    any_d = |hit_g;
    win_d = '0;
    for (int i = NWIN - 1; i >= 0; i--)
      if (hit_g[i]) win_d = IW'(i);
  end

  // Stage 2: output mux, sync/de delayed to stay aligned with rgb
  logic [PIX_W-1:0] rgb_d, rgb_q;
  logic             hs_d, hs_q, vs_d, vs_q, de_q, fs_q;
`ifdef TEST_PATTERN_EN
  logic             tm1_q;
  logic [2:0]       bar_idx;
`endif

  always_comb begin
    rgb_d = '0;
    if (any1_q)      rgb_d = pixel[int'(win1_q)*PIX_W +: PIX_W];
    else if (act1_q) rgb_d = BG_COLOR;
`ifdef TEST_PATTERN_EN
    bar_idx = 3'((int'(x_q) * 8) / H_ACTIVE);
    if (tm1_q) rgb_d = act1_q ? PIX_W'(BAR_COLORS[bar_idx]) : '0;
`endif
    hs_d = hs1_q ? SYNC_ACT : ~SYNC_ACT;
    vs_d = vs1_q ? SYNC_ACT : ~SYNC_ACT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_en_q <= '0;
      sh_xl_q <= '0;
      sh_xr_q <= '0;
      sh_yu_q <= '0;
      sh_yd_q <= '0;
      req_q   <= '0;
      win1_q  <= '0;
      any1_q  <= 1'b0;
      act1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      hs_q    <= ~SYNC_ACT;
      vs_q    <= ~SYNC_ACT;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
`ifdef TEST_PATTERN_EN
      tm1_q   <= 1'b0;
`endif
    end else begin
      sh_en_q <= sh_en_d;
      sh_xl_q <= sh_xl_d;
      sh_xr_q <= sh_xr_d;
      sh_yu_q <= sh_yu_d;
      sh_yd_q <= sh_yd_d;
      req_q   <= req_d;
      win1_q  <= win_d;
      any1_q  <= any_d;
      act1_q  <= active;
      hs1_q   <= hs_on;
      vs1_q   <= vs_on;
      fs1_q   <= frame_top;
      x_q     <= h;
      y_q     <= v;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= act1_q;
      fs_q    <= fs1_q;
`ifdef TEST_PATTERN_EN
      tm1_q   <= test_mode;
`endif
    end
  end

  assign pix_req     = req_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign rgb         = rgb_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_window_display.sv
// Directed bench on a reduced 16x12 raster (24x17 totals, 408 clks/frame).
module tb_vga_window_display;
  localparam int HT = 24, VT = 17, FT = HT * VT, NF = 5, NCYC = NF * FT + 2;
  localparam logic [11:0] BG = 12'h123;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  win_en;
  logic [19:0] win_xl, win_xr, win_yu, win_yd;
  logic [23:0] pixel;
  logic [1:0]  pix_req;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] rgb;
  logic        hs, vs, de, frame_start;
`ifdef TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  vga_window_display #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(0), .NWIN(2), .CW(10), .PIX_W(12), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .win_en(win_en), .win_xl(win_xl), .win_xr(win_xr), .win_yu(win_yu), .win_yd(win_yd),
    .pixel(pixel), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .rgb(rgb), .hs(hs), .vs(vs), .de(de), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_asserts = 0, n_fail = 0;
  int fen[8][2], fxl[8][2], fxr[8][2], fyu[8][2], fyd[8][2];
  int cnt0[8], cnt1[8], cde[8], chs[8], cvs[8], cfs[8];
  int first_fs = -1;
  int exp0[NF] = '{16, 16, 16, 4, 0};
  int exp1[NF] = '{0, 21, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic set_win(input int i, input int xl, input int xr, input int yu, input int yd);
    win_xl[i*10 +: 10] = 10'(xl);
    win_xr[i*10 +: 10] = 10'(xr);
    win_yu[i*10 +: 10] = 10'(yu);
    win_yd[i*10 +: 10] = 10'(yd);
  endtask

  task automatic cap(input int f);
    for (int i = 0; i < 2; i++) begin
      fen[f][i] = int'(win_en[i]);
      fxl[f][i] = int'(win_xl[i*10 +: 10]);
      fxr[f][i] = int'(win_xr[i*10 +: 10]);
      fyu[f][i] = int'(win_yu[i*10 +: 10]);
      fyd[f][i] = int'(win_yd[i*10 +: 10]);
    end
  endtask

  function automatic void model(input int n, output logic [11:0] e_rgb, output logic e_de,
                                output logic e_hs, output logic e_vs, output logic e_fs,
                                output logic [1:0] e_req, output int h, output int v);
    int f;
    logic act;
    logic [1:0] ht;
    logic [3:0] hb, vb;
    f = n / FT;
    h = n % HT;
    v = (n / HT) % VT;
    act = (h < 16) && (v < 12);
    for (int i = 0; i < 2; i++)
      ht[i] = (fen[f][i] != 0) && act && h >= fxl[f][i] && h <= fxr[f][i] &&
              v >= fyu[f][i] && v <= fyd[f][i];
    hb = 4'(h);
    vb = 4'(v);
    e_de  = act;
    e_hs  = !(h >= 18 && h < 21);
    e_vs  = !(v >= 13 && v < 15);
    e_fs  = (h == 0) && (v == 0);
    e_req = ht[0] ? 2'b01 : (ht[1] ? 2'b10 : 2'b00);
    e_rgb = ht[0] ? {4'h8, hb, vb} : (ht[1] ? {4'h4, hb, vb} : (act ? BG : 12'h000));
  endfunction

  initial begin
    logic [11:0] e_rgb;
    logic        e_de, e_hs, e_vs, e_fs;
    logic [1:0]  e_req;
    int          eh, ev, f;

    win_en = 2'b01;
    win_xl = '0; win_xr = '0; win_yu = '0; win_yd = '0;
    set_win(0, 2, 5, 3, 6);
    set_win(1, 2, 6, 2, 6);
    pixel = {12'hBAD, 12'hBAD};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (37) @(negedge clk);
    // mid-line abort
    rst = 1'b0;
    #1;
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_de", de, 1'b0);
    chk("rst_hs", hs, 1'b1);
    chk("rst_vs", vs, 1'b1);
    chk("rst_req", pix_req, 2'b00);
    chk("rst_fs", frame_start, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_hold_rgb", rgb, 12'h000);
    cap(0);
    rst = 1'b1;

    for (int k = 1; k <= NCYC; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        model(k - 2, e_rgb, e_de, e_hs, e_vs, e_fs, e_req, eh, ev);
      end else begin
        e_rgb = 12'h000; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
      end
      chk($sformatf("rgb_k%0d", k), rgb, e_rgb);
      chk($sformatf("de_k%0d", k), de, e_de);
      chk($sformatf("hs_k%0d", k), hs, e_hs);
      chk($sformatf("vs_k%0d", k), vs, e_vs);
      chk($sformatf("fs_k%0d", k), frame_start, e_fs);
      if (frame_start === 1'b1 && first_fs < 0) first_fs = k;
      if (k >= 2 && (k - 2) / FT < NF) begin
        f = (k - 2) / FT;
        cde[f] += int'(de);
        chs[f] += int'(hs == 1'b0);
        cvs[f] += int'(vs == 1'b0);
        cfs[f] += int'(frame_start);
      end

      model(k - 1, e_rgb, e_de, e_hs, e_vs, e_fs, e_req, eh, ev);
      chk($sformatf("req_k%0d", k), pix_req, e_req);
      chk($sformatf("px_k%0d", k), pix_x, eh);
      chk($sformatf("py_k%0d", k), pix_y, ev);
      if ((k - 1) / FT < NF) begin
        f = (k - 1) / FT;
        cnt0[f] += int'(pix_req[0]);
        cnt1[f] += int'(pix_req[1]);
      end

      // sources answer on the next clk; unrequested sources drive junk
      pixel[11:0]  = pix_req[0] ? {4'h8, pix_x[3:0], pix_y[3:0]} : 12'hBAD;
      pixel[23:12] = pix_req[1] ? {4'h4, pix_x[3:0], pix_y[3:0]} : 12'hBAD;

      if (k == FT - 100) begin
        win_en = 2'b11;
        set_win(0, 0, 3, 0, 3);
        set_win(1, 2, 6, 2, 6);
      end else if (k == 2 * FT - 100) begin
        win_en = 2'b01;
        set_win(0, 2, 5, 3, 6);
      end else if (k == 2 * FT + 150) begin
        set_win(0, 10, 11, 10, 11);
      end else if (k == 4 * FT - 100) begin
        win_en = 2'b11;
        set_win(0, 12, 8, 0, 11);
        set_win(1, 0, 15, 9, 3);
      end
      if (k % FT == 0 && k / FT < 8) cap(k / FT);
    end

    chk("first_fs_clk", first_fs, 2);
    for (int i = 0; i < NF; i++) begin
      chk($sformatf("reads0_f%0d", i), cnt0[i], exp0[i]);
      chk($sformatf("reads1_f%0d", i), cnt1[i], exp1[i]);
      chk($sformatf("de_cnt_f%0d", i), cde[i], 192);
      chk($sformatf("hs_low_f%0d", i), chs[i], 51);
      chk($sformatf("vs_low_f%0d", i), cvs[i], 48);
      chk($sformatf("fs_cnt_f%0d", i), cfs[i], 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
